// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator (pixel/line counters, syncs, blanking).
// Every output is registered from the *next* counter value, so it lines up
// with the count being loaded on that edge (zero latency relative to the count).
// Optional feature macro: VGA_FRAME_CNT_EN adds an 8-bit frame_cnt output.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_clk,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic       h_sync,
  output logic       v_sync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  , output logic [7:0] frame_cnt
`endif
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;
  logic       h_wrap, v_wrap, vis_nxt;

  // Next raster position; outputs are decoded from this so they match the new count.
  always_comb begin
    h_wrap  = (h_cnt == H_LAST);
    v_wrap  = (v_cnt == V_LAST);
    h_nxt   = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_nxt   = v_cnt;
    if (h_wrap) v_nxt = v_wrap ? 10'd0 : v_cnt + 10'd1;
    vis_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
  end

  // Counters and registered outputs; everything holds while pix_clk is low
  // except the start pulses, which must drop after one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      video_on    <= 1'b1;
      h_sync      <= ~SYNC_POL;
      v_sync      <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_clk) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      // Blanking forces zero so the 9-bit pix_y never aliases a visible row.
      pix_x       <= vis_nxt ? h_nxt : 10'd0;
      pix_y       <= vis_nxt ? v_nxt[8:0] : 9'd0;
      video_on    <= vis_nxt;
      h_sync      <= ((h_nxt >= HS_BEG) && (h_nxt <= HS_END)) ? SYNC_POL : ~SYNC_POL;
      // v_nxt only moves on an h wrap, so v_sync changes only then.
      v_sync      <= ((v_nxt >= VS_BEG) && (v_nxt <= VS_END)) ? SYNC_POL : ~SYNC_POL;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Frame counter steps on the same edge that raises frame_start; wraps 255->0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          frame_cnt <= '0;
    else if (pix_clk && h_wrap && v_wrap) frame_cnt <= frame_cnt + 8'd1;
  end
`endif

endmodule
